accel_host_ctrl: RTL and testbench
==================================

Name: accel_host_ctrl

Overview:
- Host-side counterpart of the matrix accelerator: drives the accelerator from the other end of its memory and control interface.
- Streams a job's input words into input memory, pulses/holds `comp_enb`, waits for `done`, then reads the result memory back and streams it out.
- Sits between the system host stream and the accelerator + input/result RAM pair, replacing the testbench-driven preload and dump.

Parameters:
- DATA_W, 64, memory word width.
- ADDR_W, 16, memory address width.
- START_HOLD, 10, cycles `comp_enb` is held high per job (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_start  in  1  one-cycle job start; sampled only in IDLE
- load_len  in  ADDR_W  input words to load, latched at cmd_start
- res_base  in  ADDR_W  first result-memory address to read, latched at cmd_start
- res_len  in  ADDR_W  result words to read, latched at cmd_start
- s_valid  in  1  input stream valid
- s_data  in  DATA_W  input stream word
- s_ready  out  1  input stream ready
- in_mem_addr  out  ADDR_W  input RAM address
- in_mem_data  out  DATA_W  input RAM write data
- in_mem_we  out  1  input RAM write strobe, 1 = write
- comp_enb  out  1  accelerator start level
- busyb  in  1  accelerator busy, active low
- done  in  1  accelerator completion pulse
- res_mem_addr  out  ADDR_W  result RAM read address
- res_mem_rd  out  1  result RAM read strobe
- res_mem_q  in  DATA_W  result RAM read data; valid exactly 1 cycle after `res_mem_rd`
- m_valid  out  1  result stream valid
- m_data  out  DATA_W  result stream word
- m_last  out  1  marks final result word
- m_ready  in  1  result stream ready
- job_busy  out  1  high from accepted cmd_start through FIN
- job_err  out  1  sticky error flag; cleared by next accepted cmd_start

Behaviour:
- Reset: state IDLE. All outputs 0: s_ready, in_mem_we, comp_enb, res_mem_rd, m_valid, m_last, job_busy, job_err, all addr/data buses. Counters and skid buffer cleared. Reset in any state aborts the job the following cycle with no further RAM writes.
- IDLE: on cmd_start, latch lengths and res_base. Go to LOAD, or to START if load_len==0. cmd_start outside IDLE is ignored.
- LOAD: s_ready=1. Each s_valid&s_ready writes s_data at address 0..load_len-1 the same cycle, registered: in_mem_we high for one cycle per word. After word load_len-1 → START.
- START: comp_enb=1 for exactly START_HOLD cycles, then 0 → WAIT.
  - `done` seen during START is latched; START then goes directly to DRAIN, or FIN if res_len==0.
- WAIT: on done → DRAIN, or FIN if res_len==0. busyb is informational only.
- DRAIN:
  - Issue reads res_base .. res_base+res_len-1. Address wraps modulo 2^ADDR_W.
  - 2-entry skid buffer. A read is issued only if (entries held + reads in flight) < 2, so `m_ready` backpressure never drops or duplicates a word.
  - m_data holds stable while m_valid&!m_ready.
  - m_last=1 with the res_len-th word. On its handshake → FIN.
- FIN: one cycle, job_busy falls, → IDLE.
- Counters are ADDR_W wide. load_len/res_len of 2^ADDR_W-1 are supported; the value 0 means none.
- Simultaneous done and the last START cycle: treated as done-in-START.

Optional Feature:
- Macro: ACC_HOST_TIMEOUT_EN.
- Defined: 24-bit watchdog counts cycles in WAIT.
  - Reaching 24'hFFFFFF sets job_err and goes to FIN, skipping DRAIN.
  - Watchdog resets on entry to WAIT.
- Undefined: no watchdog; WAIT waits indefinitely; job_err is tied 0.

Test Plan:
- Reset: hold rst_n=0 3 cycles mid-LOAD → all outputs 0 next cycle, state IDLE, no in_mem_we after reset.
- Basic job: load_len=4, words 0x11..0x44, res_base=0x0100, res_len=3.
  - in_mem_we at addresses 0..3.
  - comp_enb high exactly 10 cycles.
  - done after 50 cycles → reads 0x0100..0x0102.
  - m_last on the 3rd word; job_busy falls after FIN.
- Backpressure: res_len=8 with m_ready toggled 1/0 every cycle plus a 5-cycle stall → all 8 words delivered in order, none duplicated, m_data stable while stalled.
- Edge lengths: load_len=0, res_len=0 → START→WAIT→FIN; no RAM writes or reads. Separately, res_base=0xFFFE, res_len=3 → addresses FFFE, FFFF, 0000.
- Early done: done asserted in START cycle 4 → comp_enb still completes 10 cycles, then DRAIN without entering WAIT. A cmd_start during the job is ignored.
- Timeout (ACC_HOST_TIMEOUT_EN): never assert done → job_err=1 after 2^24-1 WAIT cycles, no reads issued. job_err clears at the next cmd_start.

Source files
------------

// File: rtl/accel_host_ctrl.sv
// ---------------------------------------------------------------------------
// accel_host_ctrl
//
// Host-side controller for the matrix accelerator. For one job it streams the
// input words into the input RAM, holds comp_enb high for START_HOLD cycles,
// waits for the accelerator's done pulse, then reads the result RAM back and
// streams the words out.
//
// Optional feature (compile-time macro ACC_HOST_TIMEOUT_EN):
//   defined   - a 24-bit watchdog counts cycles spent in WAIT; when it reaches
//               24'hFFFFFF the job is abandoned (no result reads) and job_err
//               is set until the next accepted cmd_start.
//   undefined - WAIT waits for done indefinitely and job_err is tied 0.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_start                     one-cycle job start, accepted only in IDLE
//   load_len, res_base, res_len   job descriptor, latched at cmd_start
//   s_valid, s_data, s_ready      input word stream (host -> input RAM)
//   in_mem_addr/data/we           input RAM write port
//   comp_enb                      accelerator start level
//   busyb, done                   accelerator status (busyb informational)
//   res_mem_addr/rd, res_mem_q    result RAM read port, 1-cycle read latency
//   m_valid, m_data, m_last,
//   m_ready                       result word stream (result RAM -> host)
//   job_busy                      high from accepted cmd_start through FIN
//   job_err                       sticky watchdog error flag
// ---------------------------------------------------------------------------
module accel_host_ctrl #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 16,
  parameter int START_HOLD = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [ADDR_W-1:0] res_base,
  input  logic [ADDR_W-1:0] res_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] in_mem_addr,
  output logic [DATA_W-1:0] in_mem_data,
  output logic              in_mem_we,
  output logic              comp_enb,
  input  logic              busyb,
  input  logic              done,
  output logic [ADDR_W-1:0] res_mem_addr,
  output logic              res_mem_rd,
  input  logic [DATA_W-1:0] res_mem_q,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              job_busy,
  output logic              job_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN,
    ST_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [31:0] HOLD_LAST = 32'(START_HOLD - 1);

  state_t state;

  logic [ADDR_W-1:0] load_len_r;
  logic [ADDR_W-1:0] res_base_r;
  logic [ADDR_W-1:0] res_len_r;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       hold_cnt;
  logic              done_seen;

  // Drain bookkeeping: reads still to issue, words still to deliver, the
  // next read address, a flag for data arriving on res_mem_q this cycle, and
  // the skid buffer (m_data is the head entry, skid1 the second).
  logic [ADDR_W-1:0] rd_left;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] out_left;
  logic              q_valid;
  logic [1:0]        fill;
  logic [DATA_W-1:0] skid1;

`ifdef ACC_HOST_TIMEOUT_EN
  logic [23:0]       wd_cnt;
`endif

  // busyb carries no control meaning here; it is only brought in for
  // observability at the port.
  logic unused_busyb;
  assign unused_busyb = busyb;

  logic              pop;
  logic [1:0]        fill_pop;
  logic [1:0]        fill_n;
  logic [DATA_W-1:0] head_n;
  logic [DATA_W-1:0] skid1_n;
  logic [ADDR_W-1:0] out_left_n;
  logic              issue;

  // Skid buffer next state. A pop shifts the second entry into the head; an
  // arriving read word lands in the first free slot after the pop. A new read
  // is issued only while buffered words plus the read already on the RAM
  // port stay below two, so the buffer can never overflow under backpressure.
  always_comb begin
    pop        = m_valid & m_ready;
    fill_pop   = fill - {1'b0, pop};
    fill_n     = fill_pop + {1'b0, q_valid};
    head_n     = m_data;
    skid1_n    = skid1;
    out_left_n = out_left - {{(ADDR_W-1){1'b0}}, pop};
    if (pop) begin
      head_n = skid1;
    end
    if (q_valid) begin
      if (fill_pop == 2'd0) begin
        head_n = res_mem_q;
      end else begin
        skid1_n = res_mem_q;
      end
    end
    issue = (state == ST_DRAIN) && (rd_left != '0) &&
            (({1'b0, fill_n} + {2'b00, res_mem_rd}) < 3'd2);
  end

  // Main job sequencer; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      load_len_r   <= '0;
      res_base_r   <= '0;
      res_len_r    <= '0;
      ld_addr      <= '0;
      hold_cnt     <= '0;
      done_seen    <= 1'b0;
      rd_left      <= '0;
      rd_addr      <= '0;
      out_left     <= '0;
      q_valid      <= 1'b0;
      fill         <= 2'd0;
      skid1        <= '0;
      s_ready      <= 1'b0;
      in_mem_addr  <= '0;
      in_mem_data  <= '0;
      in_mem_we    <= 1'b0;
      comp_enb     <= 1'b0;
      res_mem_addr <= '0;
      res_mem_rd   <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      job_busy     <= 1'b0;
`ifdef ACC_HOST_TIMEOUT_EN
      job_err      <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      in_mem_we  <= 1'b0;
      res_mem_rd <= 1'b0;

      // Outside DRAIN keep the drain counters primed from the latched job
      // descriptor, so every path into DRAIN starts from a clean state.
      if (state != ST_DRAIN) begin
        rd_left  <= res_len_r;
        rd_addr  <= res_base_r;
        out_left <= res_len_r;
        q_valid  <= 1'b0;
        fill     <= 2'd0;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            load_len_r <= load_len;
            res_base_r <= res_base;
            res_len_r  <= res_len;
            ld_addr    <= '0;
            job_busy   <= 1'b1;
`ifdef ACC_HOST_TIMEOUT_EN
            job_err    <= 1'b0;
`endif
            if (load_len == '0) begin
              state     <= ST_START;
              comp_enb  <= 1'b1;
              hold_cnt  <= '0;
              done_seen <= 1'b0;
            end else begin
              state   <= ST_LOAD;
              s_ready <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (s_valid) begin
            in_mem_we   <= 1'b1;
            in_mem_addr <= ld_addr;
            in_mem_data <= s_data;
            ld_addr     <= ld_addr + ONE;
            if (ld_addr == load_len_r - ONE) begin
              s_ready   <= 1'b0;
              state     <= ST_START;
              comp_enb  <= 1'b1;
              hold_cnt  <= '0;
              done_seen <= 1'b0;
            end
          end
        end

        // A done arriving while comp_enb is still held (including the final
        // hold cycle) is remembered so the job skips WAIT entirely.
        ST_START: begin
          hold_cnt  <= hold_cnt + 32'd1;
          done_seen <= done_seen | done;
          if (hold_cnt == HOLD_LAST) begin
            comp_enb <= 1'b0;
            if (done_seen | done) begin
              state <= (res_len_r == '0) ? ST_FIN : ST_DRAIN;
            end else begin
              state <= ST_WAIT;
`ifdef ACC_HOST_TIMEOUT_EN
              wd_cnt <= '0;
`endif
            end
          end
        end

        ST_WAIT: begin
          if (done) begin
            state <= (res_len_r == '0) ? ST_FIN : ST_DRAIN;
          end
`ifdef ACC_HOST_TIMEOUT_EN
          else if (wd_cnt == 24'hFFFFFF) begin
            job_err <= 1'b1;
            state   <= ST_FIN;
          end else begin
            wd_cnt <= wd_cnt + 24'd1;
          end
`endif
        end

        ST_DRAIN: begin
          fill     <= fill_n;
          m_data   <= head_n;
          skid1    <= skid1_n;
          q_valid  <= res_mem_rd;
          out_left <= out_left_n;
          m_valid  <= (fill_n != 2'd0);
          m_last   <= (fill_n != 2'd0) && (out_left_n == ONE);
          if (issue) begin
            res_mem_rd   <= 1'b1;
            res_mem_addr <= rd_addr;
            rd_addr      <= rd_addr + ONE;
            rd_left      <= rd_left - ONE;
          end
          if (pop && (out_left == ONE)) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            state   <= ST_FIN;
          end
        end

        ST_FIN: begin
          job_busy <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef ACC_HOST_TIMEOUT_EN
  assign job_err = 1'b0;
`endif

endmodule

// File: tb/tb_accel_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_accel_host_ctrl
//
// Self-checking bench for accel_host_ctrl (default build, watchdog disabled).
// A table of jobs (descriptor, done timing, backpressure mode and
// hand-computed expectations) is run in a loop; a mid-LOAD reset sequence is
// written out by hand. The result RAM is modelled with a 1-cycle read
// latency and returns a word derived from its address.
// ---------------------------------------------------------------------------
module tb_accel_host_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_start;
  logic [15:0] load_len;
  logic [15:0] res_base;
  logic [15:0] res_len;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_ready;
  logic [15:0] in_mem_addr;
  logic [63:0] in_mem_data;
  logic        in_mem_we;
  logic        comp_enb;
  logic        busyb;
  logic        done;
  logic [15:0] res_mem_addr;
  logic        res_mem_rd;
  logic [63:0] res_mem_q;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic        job_busy;
  logic        job_err;

  accel_host_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_start    (cmd_start),
    .load_len     (load_len),
    .res_base     (res_base),
    .res_len      (res_len),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .in_mem_addr  (in_mem_addr),
    .in_mem_data  (in_mem_data),
    .in_mem_we    (in_mem_we),
    .comp_enb     (comp_enb),
    .busyb        (busyb),
    .done         (done),
    .res_mem_addr (res_mem_addr),
    .res_mem_rd   (res_mem_rd),
    .res_mem_q    (res_mem_q),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .job_busy     (job_busy),
    .job_err      (job_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bp_mode = 0;

  function automatic logic [63:0] resWord(input logic [15:0] a);
    return 64'hC0DE_0000_0000_0000 | {48'h0, a};
  endfunction

  function automatic logic [63:0] inWord(input int i);
    return 64'h11 * 64'(i + 1);
  endfunction

  // Result RAM: data is valid only in the cycle after the read strobe.
  always @(posedge clk) begin
    res_mem_q <= res_mem_rd ? resWord(res_mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  // m_ready driver: always ready, or toggling every cycle with a 5-cycle
  // stall counted in cycles where m_valid is high.
  initial begin
    int vcnt;
    vcnt = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!job_busy) vcnt = 0;
      if (bp_mode == 0) begin
        m_ready = 1'b1;
      end else begin
        m_ready = !(vcnt >= 4 && vcnt < 9) && vcnt[0];
      end
      if (m_valid) vcnt = vcnt + 1;
    end
  end

  // Monitors: sampled 2 time units after each rising edge; they only append.
  logic [15:0] wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  logic [15:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [63:0] out_data_q[$];
  logic        out_last_q[$];
  int comp_hi = 0;
  int comp_rise = 0;
  int comp_fall_cyc = 0;
  int stall_err = 0;

  initial begin
    int   cyc;
    logic prev_comp;
    logic prev_stall;
    logic [63:0] prev_data;
    cyc = 0;
    prev_comp = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc = cyc + 1;
      if (in_mem_we) begin
        wr_addr_q.push_back(in_mem_addr);
        wr_data_q.push_back(in_mem_data);
      end
      if (res_mem_rd) begin
        rd_addr_q.push_back(res_mem_addr);
        rd_cyc_q.push_back(cyc);
      end
      if (comp_enb) comp_hi = comp_hi + 1;
      if (comp_enb && !prev_comp) comp_rise = comp_rise + 1;
      if (!comp_enb && prev_comp) comp_fall_cyc = cyc;
      prev_comp = comp_enb;
      if (prev_stall && !(m_valid && m_data == prev_data)) stall_err = stall_err + 1;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) begin
        out_data_q.push_back(m_data);
        out_last_q.push_back(m_last);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [191:0] act,
                             input logic [191:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] allOut();
    return {24'h0, s_ready, in_mem_addr, in_mem_data, in_mem_we, comp_enb,
            res_mem_addr, res_mem_rd, m_valid, m_data, m_last, job_busy, job_err};
  endfunction

  typedef struct {
    logic [15:0] load_len;
    logic [15:0] res_base;
    logic [15:0] res_len;
    int          early_cyc;
    int          done_delay;
    int          bp;
    bit          poke;
    int          exp_writes;
    int          exp_reads;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } job_t;

  job_t jobs[5];

  // Pulse cmd_start with the job descriptor and stream the input words.
  task automatic applyStimulus(input job_t j);
    int i;
    int guard;
    bit hs;
    @(negedge clk);
    cmd_start = 1'b1;
    load_len  = j.load_len;
    res_base  = j.res_base;
    res_len   = j.res_len;
    @(negedge clk);
    cmd_start = 1'b0;
    checkOutput("busy_after_start", 192'(job_busy), 192'd1);
    i = 0;
    guard = 0;
    while (i < int'(j.load_len) && guard < 1000) begin
      s_valid = 1'b1;
      s_data  = inWord(i);
      hs = s_ready;
      @(negedge clk);
      if (hs) i = i + 1;
      guard = guard + 1;
    end
    s_valid = 1'b0;
    checkOutput("load_words_sent", 192'(i), 192'(j.load_len));
  endtask

  task automatic runJob(input job_t j);
    int wb, rb, ob;
    int guard;
    int comp0, rise0, stall0;
    wb = wr_addr_q.size();
    rb = rd_addr_q.size();
    ob = out_data_q.size();
    comp0 = comp_hi;
    rise0 = comp_rise;
    stall0 = stall_err;
    bp_mode = j.bp;

    applyStimulus(j);

    guard = 0;
    while (!comp_enb && guard < 50) begin
      @(negedge clk);
      guard = guard + 1;
    end
    checkOutput("comp_rise_seen", 192'(comp_enb), 192'd1);

    if (j.early_cyc > 0) begin
      // This negedge is START cycle 1.
      repeat (j.early_cyc - 1) begin
        @(negedge clk);
        if (j.poke && !cmd_start && !done) begin
          cmd_start = 1'b1;
          load_len  = 16'd7;
          res_base  = 16'h0AAA;
          res_len   = 16'd9;
        end else begin
          cmd_start = 1'b0;
        end
      end
      cmd_start = 1'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end else begin
      guard = 0;
      while (comp_enb && guard < 50) begin
        @(negedge clk);
        guard = guard + 1;
      end
      checkOutput("comp_fall_seen", 192'(comp_enb), 192'd0);
      repeat (j.done_delay - 1) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end

    guard = 0;
    while (job_busy && guard < 3000) begin
      @(negedge clk);
      guard = guard + 1;
    end
    checkOutput("busy_fell", 192'(job_busy), 192'd0);
    @(negedge clk);

    checkOutput("comp_cycles", 192'(comp_hi - comp0), 192'd10);
    checkOutput("comp_rises", 192'(comp_rise - rise0), 192'd1);
    checkOutput("write_count", 192'(wr_addr_q.size() - wb), 192'(j.exp_writes));
    for (int k = 0; k < j.exp_writes && (wb + k) < wr_addr_q.size(); k++) begin
      checkOutput("write_addr", 192'(wr_addr_q[wb + k]), 192'(k));
      checkOutput("write_data", 192'(wr_data_q[wb + k]), 192'(inWord(k)));
    end
    checkOutput("read_count", 192'(rd_addr_q.size() - rb), 192'(j.exp_reads));
    if (j.exp_reads > 0 && rd_addr_q.size() > rb) begin
      checkOutput("read_first", 192'(rd_addr_q[rb]), 192'(j.exp_first));
      checkOutput("read_last", 192'(rd_addr_q[rd_addr_q.size() - 1]), 192'(j.exp_last));
      if (j.early_cyc > 0) begin
        checkOutput("drain_no_wait", 192'(rd_cyc_q[rb] - comp_fall_cyc), 192'd1);
      end
    end
    for (int k = 0; k < j.exp_reads && (rb + k) < rd_addr_q.size(); k++) begin
      checkOutput("read_addr_seq", 192'(rd_addr_q[rb + k]), 192'(16'(j.res_base + 16'(k))));
    end
    checkOutput("out_count", 192'(out_data_q.size() - ob), 192'(j.exp_reads));
    for (int k = 0; k < j.exp_reads && (ob + k) < out_data_q.size(); k++) begin
      checkOutput("out_data", 192'(out_data_q[ob + k]),
                  192'(resWord(16'(j.res_base + 16'(k)))));
      checkOutput("out_last", 192'(out_last_q[ob + k]), 192'(k == j.exp_reads - 1));
    end
    checkOutput("stall_stable", 192'(stall_err - stall0), 192'd0);
    checkOutput("job_err_low", 192'(job_err), 192'd0);
  endtask

  initial begin
    int wb;
    rst_n = 1'b0;
    cmd_start = 1'b0;
    load_len = '0;
    res_base = '0;
    res_len = '0;
    s_valid = 1'b0;
    s_data = '0;
    busyb = 1'b1;
    done = 1'b0;

    //           load   base      rlen  early dly bp poke wr rd first     last
    jobs[0] = '{16'd4, 16'h0100, 16'd3, 0,   50, 0, 1'b0, 4, 3, 16'h0100, 16'h0102};
    jobs[1] = '{16'd2, 16'h0200, 16'd8, 0,   10, 1, 1'b0, 2, 8, 16'h0200, 16'h0207};
    jobs[2] = '{16'd0, 16'h0300, 16'd0, 0,    5, 0, 1'b0, 0, 0, 16'h0000, 16'h0000};
    jobs[3] = '{16'd1, 16'hFFFE, 16'd3, 0,    7, 1, 1'b0, 1, 3, 16'hFFFE, 16'h0000};
    jobs[4] = '{16'd3, 16'h0040, 16'd2, 4,    0, 0, 1'b1, 3, 2, 16'h0040, 16'h0041};

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOut(), 192'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 5; n++) begin
      $display("[TB] job %0d", n);
      runJob(jobs[n]);
    end

    // Reset in the middle of LOAD.
    $display("[TB] reset during load");
    bp_mode = 0;
    wb = wr_addr_q.size();
    @(negedge clk);
    cmd_start = 1'b1;
    load_len = 16'd8;
    res_base = 16'h0010;
    res_len = 16'd2;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data = inWord(i);
      @(negedge clk);
    end
    checkOutput("pre_reset_writes", 192'(wr_addr_q.size() - wb), 192'd3);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_outputs", allOut(), 192'd0);
    wb = wr_addr_q.size();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("post_reset_outputs", allOut(), 192'd0);
    checkOutput("post_reset_no_writes", 192'(wr_addr_q.size() - wb), 192'd0);

    // A fresh job still works after the abort.
    runJob(jobs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
